// File: rtl/oram_requester.sv
// Host-side requester for an ORAM core: accepts one command, strobes it into the ORAM,
// waits for completion and presents the response. Optional wait timeout: ORAM_REQ_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | cmd_ready high, waiting for a host command
//  ISSUE | one-cycle input_ready strobe towards the ORAM
//  WAIT  | waiting for output_ready (or the timeout, when compiled in)
//  RESP  | rsp_valid held until the host takes the response
module oram_requester #(
    parameter int A              = 8,
    parameter int D              = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rw,
    input  logic [D-1:0]     cmd_block,
    input  logic [8*A-1:0]   cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [8*A-1:0]   rsp_rdata,
    output logic             rsp_error,
    output logic [D-1:0]     rw_block_number,
    output logic [8*A-1:0]   w_value,
    output logic             rw_indicator,
    output logic             input_ready,
    input  logic [8*A-1:0]   r_value,
    input  logic             output_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   complete;
    logic   timed_out;

`ifdef ORAM_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt_q;
    logic          rsp_error_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        complete  = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // completion wins over a timeout landing in the same cycle
                if (output_ready) begin
                    complete = 1'b1;
                    state_d  = RESP;
                end
`ifdef ORAM_REQ_TIMEOUT_EN
                else if (to_cnt_q == TC_LAST) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_block_number <= '0;
            w_value         <= '0;
            rw_indicator    <= 1'b0;
            rsp_rdata       <= '0;
        end else begin
            if (accept) begin
                rw_block_number <= cmd_block;
                w_value         <= cmd_wdata;
                rw_indicator    <= cmd_rw;
            end
            if (complete) begin
                rsp_rdata <= rw_indicator ? '0 : r_value;
            end else if (timed_out) begin
                rsp_rdata <= '0;
            end
        end
    end

`ifdef ORAM_REQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                to_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (complete) begin
                rsp_error_q <= 1'b0;
            end else if (timed_out) begin
                rsp_error_q <= 1'b1;
            end
        end
    end

    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

    // cmd_ready is gated by rst_n so it reads 0 for the whole reset window
    assign cmd_ready   = rst_n && (state_q == IDLE);
    assign input_ready = (state_q == ISSUE);
    assign rsp_valid   = (state_q == RESP);

endmodule

// File: tb/tb_oram_requester.sv
// Self-checking bench for oram_requester: vector table driven through a response scoreboard,
// plus hand sequences for reset, spurious completions and back-to-back handshakes.
module tb_oram_requester;
    localparam int A  = 8;
    localparam int D  = 6;
    localparam int W  = 8 * A;
    localparam int TO = 16;
`ifdef ORAM_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_rw;
    logic [D-1:0] cmd_block;
    logic [W-1:0] cmd_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rdata;
    logic         rsp_error;
    logic [D-1:0] rw_block_number;
    logic [W-1:0] w_value;
    logic         rw_indicator;
    logic         input_ready;
    logic [W-1:0] r_value;
    logic         output_ready;

    oram_requester #(.A(A), .D(D), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_block(cmd_block), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rw_block_number(rw_block_number), .w_value(w_value),
        .rw_indicator(rw_indicator), .input_ready(input_ready),
        .r_value(r_value), .output_ready(output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic         rw;
        logic [D-1:0] blk;
        logic [W-1:0] wdata;
        logic [W-1:0] rval;
        int           lat;
        int           bp;
        bit           spur;
        logic [W-1:0] exp_rdata;
        logic         exp_err;
    } vec_t;

    typedef struct {
        logic [W-1:0] rdata;
        logic         err;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic rw, input logic [D-1:0] blk, input logic [W-1:0] wdata,
                                input logic [W-1:0] rval, input int lat, input int bp, input bit spur,
                                input logic [W-1:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.rw = rw; v.blk = blk; v.wdata = wdata; v.rval = rval;
        v.lat = lat; v.bp = bp; v.spur = spur;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check_reset_values;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_block", rw_block_number, 0);
        chk("rst_w_value", w_value, 0);
        chk("rst_rw", rw_indicator, 0);
        chk("rst_input_ready", input_ready, 0);
    endtask

    // Enters at a negedge with the DUT in IDLE; leaves at a negedge back in IDLE.
    task automatic run_txn(input vec_t v, input bit pre, input vec_t nx);
        rsp_t e;
        rsp_t g;
        int   nwait;
        int   k;
        bit   tmo;
        tmo   = TO_EN && (v.lat > TO);
        nwait = tmo ? TO : v.lat;

        chk("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_rw = v.rw; cmd_block = v.blk; cmd_wdata = v.wdata;
        e.rdata = v.exp_rdata; e.err = v.exp_err;
        sb.push_back(e);
        tick;
        cmd_valid = 1'b0; cmd_wdata = {$urandom, $urandom}; cmd_block = D'($urandom);
        chk("issue_strobe", input_ready, 1);
        chk("issue_block", rw_block_number, v.blk);
        chk("issue_rw", rw_indicator, v.rw);
        if (v.rw) chk("issue_w_value", w_value, v.wdata);
        chk("issue_cmd_ready", cmd_ready, 0);
        if (v.spur) begin
            output_ready = 1'b1; r_value = {$urandom, $urandom};
        end

        for (int i = 1; i <= nwait; i++) begin
            tick;
            output_ready = 1'b0;
            chk("wait_strobe_low", input_ready, 0);
            chk("wait_block_held", rw_block_number, v.blk);
            chk("wait_rw_held", rw_indicator, v.rw);
            if (v.rw) chk("wait_w_value_held", w_value, v.wdata);
            chk("wait_no_rsp", rsp_valid, 0);
            chk("wait_cmd_ready", cmd_ready, 0);
            if (!tmo && i == v.lat) begin
                output_ready = 1'b1; r_value = v.rval;
            end
        end
        tick;
        output_ready = 1'b0; r_value = {$urandom, $urandom};

        k = 0;
        while (!rsp_valid && k < 8) begin
            tick;
            k++;
        end
        chk("rsp_latency", k, 0);

        for (int j = 0; j < v.bp; j++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("bp_rsp_error", rsp_error, v.exp_err);
            chk("bp_cmd_ready", cmd_ready, 0);
            tick;
        end

        if (sb.size() > 0) begin
            g = sb.pop_front();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, g.rdata);
            chk("rsp_error", rsp_error, g.err);
        end
        rsp_ready = 1'b1;
        if (pre) begin
            cmd_valid = 1'b1; cmd_rw = nx.rw; cmd_block = nx.blk; cmd_wdata = nx.wdata;
        end
        tick;
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_no_issue", input_ready, 0);
    endtask

    initial begin
        vecs[0] = mk(1'b0, 6'd5,  64'h0,                64'hDEADBEEF_01234567, 3,  0, 1'b0,
                     64'hDEADBEEF_01234567, 1'b0);
        vecs[1] = mk(1'b1, 6'd63, 64'h11223344_55667788, 64'hAAAAAAAA_AAAAAAAA, 2,  0, 1'b0,
                     64'h0, 1'b0);
        vecs[2] = mk(1'b0, 6'd0,  64'h0,                64'hFFFFFFFF_FFFFFFFF, 1,  5, 1'b0,
                     64'hFFFFFFFF_FFFFFFFF, 1'b0);
        vecs[3] = mk(1'b1, 6'd42, 64'h01234567_89ABCDEF, 64'h55555555_55555555, 4,  1, 1'b1,
                     64'h0, 1'b0);
        vecs[4] = mk(1'b0, 6'd17, 64'h0,                64'h5A5A5A5A_C3C3C3C3, 16, 0, 1'b0,
                     64'h5A5A5A5A_C3C3C3C3, 1'b0);
        vecs[5] = mk(1'b0, 6'd9,  64'h0,                64'hCAFEF00D_12345678, 40, 2, 1'b0,
                     TO_EN ? 64'h0 : 64'hCAFEF00D_12345678, TO_EN);
        vecs[6] = mk(1'b0, 6'd1,  64'h0,                64'h00000000_00000001, 1,  0, 1'b1,
                     64'h00000000_00000001, 1'b0);

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_block = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; r_value = '0; output_ready = 1'b0;
        repeat (3) tick;
        check_reset_values;

        // completion strobe in the first cycle after reset release
        rst_n = 1'b1; output_ready = 1'b1; r_value = 64'h0BAD0BAD_0BAD0BAD;
        tick;
        output_ready = 1'b0;
        chk("rel_rsp_valid", rsp_valid, 0);
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_input_ready", input_ready, 0);
        tick;
        chk("rel_rsp_valid_2", rsp_valid, 0);

        for (int i = 0; i < 3; i++) begin
            output_ready = 1'b1; r_value = {$urandom, $urandom};
            tick;
            chk("idle_spur_rsp_valid", rsp_valid, 0);
            chk("idle_spur_cmd_ready", cmd_ready, 1);
            chk("idle_spur_rdata", rsp_rdata, 0);
        end
        output_ready = 1'b0;
        tick;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], (i == 2), vecs[(i < 6) ? i + 1 : i]);
            if (i == 2) chk("b2b_accept_after_handshake", rw_block_number, vecs[2].blk);
        end

        // reset in the middle of WAIT
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_block = 6'd11; cmd_wdata = 64'hA5A5A5A5_5A5A5A5A;
        tick;
        cmd_valid = 1'b0;
        chk("mr_issue", input_ready, 1);
        tick;
        tick;
        chk("mr_wait_block", rw_block_number, 6'd11);
        rst_n = 1'b0;
        tick;
        check_reset_values;
        rst_n = 1'b1; output_ready = 1'b1; r_value = 64'h0BADF00D_0BADF00D;
        tick;
        output_ready = 1'b0;
        chk("mr_late_rsp_valid", rsp_valid, 0);
        chk("mr_cmd_ready", cmd_ready, 1);
        chk("mr_input_ready", input_ready, 0);
        repeat (2) begin
            tick;
            chk("mr_idle_rsp_valid", rsp_valid, 0);
        end
        run_txn(vecs[0], 1'b0, vecs[0]);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/oram_requester.md
ORAM_REQUESTER -- requirements
Module: oram_requester

Interface
REQ-001 SHALL have parameter A, default 8, bytes per block.
REQ-002 SHALL have parameter D, default 6, block-number width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, wait limit used only when the timeout feature is compiled in.
REQ-004 clk  input  1  single clock; all logic on its rising edge; reset is synchronous and active-low.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 cmd_valid  input  1  host command present.
REQ-007 cmd_ready  output  1  requester accepts a host command.
REQ-008 cmd_rw  input  1  0 = read, 1 = write.
REQ-009 cmd_block  input  D  requested block number.
REQ-010 cmd_wdata  input  8*A  write value; ignored for reads.
REQ-011 rsp_valid  output  1  host response present.
REQ-012 rsp_ready  input  1  host accepts the response.
REQ-013 rsp_rdata  output  8*A  read value; zero for writes.
REQ-014 rsp_error  output  1  transaction timed out; always 0 when the timeout feature is compiled out.
REQ-015 rw_block_number  output  D  block number driven to the ORAM.
REQ-016 w_value  output  8*A  write value driven to the ORAM.
REQ-017 rw_indicator  output  1  0 = read, 1 = write, driven to the ORAM.
REQ-018 input_ready  output  1  one-cycle strobe: ORAM inputs valid.
REQ-019 r_value  input  8*A  ORAM read data.
REQ-020 output_ready  input  1  ORAM completion strobe, asserted for both reads and writes.

Function
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with at most one transaction outstanding.
REQ-022 IDLE SHALL drive cmd_ready=1; a cmd_valid&cmd_ready cycle SHALL register cmd_rw, cmd_block and cmd_wdata, then go to ISSUE.
REQ-023 ISSUE SHALL assert input_ready for exactly one cycle with the registered rw_block_number, w_value and rw_indicator, then go to WAIT.
REQ-024 rw_block_number, w_value and rw_indicator SHALL hold their registered values from ISSUE until the FSM leaves WAIT.
REQ-025 cmd_ready SHALL be 0 in every state except IDLE.
REQ-026 In WAIT, output_ready=1 SHALL capture r_value into rsp_rdata (or 0 if the transaction is a write), set rsp_error=0, and go to RESP.
REQ-027 output_ready SHALL be ignored in IDLE, ISSUE and RESP, with no state change and no data capture.
REQ-028 RESP SHALL hold rsp_valid=1 with rsp_rdata and rsp_error stable until rsp_ready=1, then go to IDLE.
REQ-029 Minimum latency SHALL be 1 cycle from command accept to the input_ready strobe, and 1 cycle from output_ready to rsp_valid.
REQ-030 A command SHALL NOT be accepted in the same cycle that a response is consumed; the next accept is possible one cycle later, in IDLE.

Reset
REQ-031 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE, regardless of the current state, including mid-transaction.
REQ-032 Reset values SHALL be: cmd_ready=0 during reset, then 1; rsp_valid=0, rsp_rdata=0, rsp_error=0; rw_block_number=0, w_value=0, rw_indicator=0, input_ready=0; timeout counter 0.
REQ-033 An output_ready arriving in the first cycle after reset is released SHALL be ignored.

Configuration
REQ-034 Macro ORAM_REQ_TIMEOUT_EN SHALL control the timeout feature.
REQ-035 When ORAM_REQ_TIMEOUT_EN is defined:
- a counter SHALL clear on entry to WAIT and increment each WAIT cycle;
- if it reaches TIMEOUT_CYCLES-1 without output_ready, the FSM SHALL go to RESP with rsp_error=1 and rsp_rdata=0;
- output_ready in that same cycle SHALL take priority (normal completion).
REQ-036 When ORAM_REQ_TIMEOUT_EN is undefined, no counter SHALL exist, WAIT SHALL last indefinitely, and rsp_error SHALL be tied to 0.

Verification
REQ-037 Read: cmd_rw=0, cmd_block=6'd5; ORAM returns r_value=64'hDEADBEEF_01234567 three cycles after input_ready -> one input_ready pulse with rw_block_number=5 and rw_indicator=0; rsp_valid with rsp_rdata=64'hDEADBEEF_01234567 and rsp_error=0.
REQ-038 Write: cmd_rw=1, cmd_block=6'd63, cmd_wdata=64'h1122334455667788 -> w_value and rw_indicator=1 held through WAIT; response has rsp_rdata=0.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout; next command accepted 1 cycle after the handshake.
REQ-040 Reset mid-WAIT: rst_n=0 for 1 cycle -> all outputs at reset values; a late output_ready is ignored; a new command completes normally.
REQ-041 Timeout (macro on, TIMEOUT_CYCLES=16): no output_ready -> rsp_valid with rsp_error=1 after 16 WAIT cycles; output_ready in cycle 16 -> normal response with rsp_error=0.
REQ-042 Spurious output_ready while IDLE -> no rsp_valid and no state change.
